// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: turns one pipeline memory op into a single
// data-bus word transaction, formats load results and flags misaligned/illegal ops.
module mem_access_unit #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        load_in,
  input  logic        store_in,
  input  logic [31:0] alu_res,
  input  logic [31:0] op_b,
  input  logic [31:0] instruction_in,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_wmask,
  input  logic        dbus_ready,
  input  logic [31:0] dbus_rdata,
  output logic        stall_mem,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        access_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [1:0]  state;
  logic [31:0] addr_q, opb_q;
  logic [2:0]  f3_q;
  logic        store_q;
  logic [7:0]  wait_cnt;

  logic [2:0]  f3;
  logic        start, bad;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ld_fmt;
  logic        unused_bits;

  assign f3          = instruction_in[14:12];
  assign unused_bits = ^{instruction_in[31:15], instruction_in[11:0]};
  assign start       = mem_en & (load_in | store_in);

  always_comb begin
    bad = 1'b0;
    if (load_in && store_in)                                 bad = 1'b1;
    else if (load_in && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) bad = 1'b1;
    else if (store_in && f3 >= 3'd3)                         bad = 1'b1;
    else if (f3[1:0] == 2'd1 && alu_res[0])                  bad = 1'b1;
    else if (f3[1:0] == 2'd2 && alu_res[1:0] != 2'd0)        bad = 1'b1;
  end

  // Load result: pick the addressed lane, then extend by funct3.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    rbyte = dbus_rdata[7:0];
      2'd1:    rbyte = dbus_rdata[15:8];
      2'd2:    rbyte = dbus_rdata[23:16];
      default: rbyte = dbus_rdata[31:24];
    endcase
    rhalf = addr_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (f3_q)
      3'd0:    ld_fmt = {{24{rbyte[7]}}, rbyte};
      3'd1:    ld_fmt = {{16{rhalf[15]}}, rhalf};
      3'd4:    ld_fmt = {24'd0, rbyte};
      3'd5:    ld_fmt = {16'd0, rhalf};
      default: ld_fmt = dbus_rdata;
    endcase
  end

  always_comb begin
    dbus_wmask = 4'b0000;
    dbus_wdata = opb_q;
    if (store_q) begin
      case (f3_q[1:0])
        2'd0: begin
          dbus_wmask = 4'b0001 << addr_q[1:0];
          dbus_wdata = {4{opb_q[7:0]}};
        end
        2'd1: begin
          dbus_wmask = 4'b0011 << addr_q[1:0];
          dbus_wdata = {2{opb_q[15:0]}};
        end
        default: dbus_wmask = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      load_data <= 32'd0;
      addr_q    <= 32'd0;
      opb_q     <= 32'd0;
      f3_q      <= 3'd0;
      store_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          addr_q   <= alu_res;
          opb_q    <= op_b;
          f3_q     <= f3;
          store_q  <= store_in;
          wait_cnt <= 8'd0;
          state    <= bad ? ERR : REQ;
        end
        REQ: begin
          if (dbus_ready) begin
            if (!store_q) load_data <= ld_fmt;
            state <= DONE;
          end else if (wait_cnt == TMO_LAST) begin
            state <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset forces stall low combinationally so the pipeline drains during reset.
  assign stall_mem  = ~rst & (((state == IDLE) & start) | (state == REQ));
  assign dbus_req   = (state == REQ);
  assign dbus_we    = (state == REQ) & store_q;
  assign dbus_addr  = {addr_q[31:2], 2'b00};
  assign load_valid = (state == DONE) & ~store_q;
  assign access_err = (state == ERR);

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a transaction-level driver predicts
// every cycle of each operation and a negedge process compares all outputs.
module tb_mem_access_unit;
  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst, mem_en, load_in, store_in;
  logic [31:0] alu_res, op_b, instruction_in;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_wmask;
  logic        dbus_ready;
  logic [31:0] dbus_rdata;
  logic        stall_mem;
  logic [31:0] load_data;
  logic        load_valid, access_err;

  mem_access_unit #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .load_in(load_in), .store_in(store_in),
    .alu_res(alu_res), .op_b(op_b), .instruction_in(instruction_in),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_wmask(dbus_wmask),
    .dbus_ready(dbus_ready), .dbus_rdata(dbus_rdata),
    .stall_mem(stall_mem), .load_data(load_data),
    .load_valid(load_valid), .access_err(access_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic        e_stall, e_req, e_we, e_lv, e_err;
  logic [31:0] e_addr, e_wdata, e_ld;
  logic [3:0]  e_wmask;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("stall_mem",  {31'd0, stall_mem},  {31'd0, e_stall});
    chk("dbus_req",   {31'd0, dbus_req},   {31'd0, e_req});
    chk("dbus_we",    {31'd0, dbus_we},    {31'd0, e_we});
    chk("load_valid", {31'd0, load_valid}, {31'd0, e_lv});
    chk("access_err", {31'd0, access_err}, {31'd0, e_err});
    chk("load_data",  load_data, e_ld);
    if (e_req) begin
      chk("dbus_addr",  dbus_addr, e_addr);
      chk("dbus_wmask", {28'd0, dbus_wmask}, {28'd0, e_wmask});
      if (e_we) chk("dbus_wdata", dbus_wdata, e_wdata);
    end
  end

  // ---- reference rules ----
  function automatic logic is_bad(logic ld, logic st, logic [2:0] f3, logic [31:0] a);
    if (ld && st) return 1'b1;
    if (ld && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
    if (st && f3 >= 3) return 1'b1;
    if (f3[1:0] == 2'd1 && a[0]) return 1'b1;
    if (f3[1:0] == 2'd2 && a[1:0] != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] fmt(logic [2:0] f3, logic [1:0] a, logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * a);
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd4:    return {24'd0, sh[7:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] mask_of(logic st, logic [2:0] f3, logic [1:0] a);
    if (!st) return 4'b0000;
    case (f3)
      3'd0:    return 4'(1 << a);
      3'd1:    return 4'(3 << a);
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_of(logic [2:0] f3, logic [31:0] d);
    case (f3)
      3'd0:    return {4{d[7:0]}};
      3'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // ---- driver ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_exp();
    e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0; e_lv = 1'b0; e_err = 1'b0;
  endtask

  // Inputs the DUT must ignore outside IDLE.
  task automatic noise();
    mem_en = 1'($urandom); load_in = 1'($urandom); store_in = 1'($urandom);
    alu_res = $urandom; op_b = $urandom; instruction_in = $urandom;
    dbus_ready = 1'($urandom); dbus_rdata = $urandom;
  endtask

  task automatic idle_cycle();
    noise();
    load_in = 1'b0; store_in = 1'b0;
    idle_exp();
    tick();
  endtask

  task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rd, input int wait_n);
    logic [31:0] ins;
    int nreq;
    ins = $urandom;
    ins[14:12] = f3;
    noise();
    mem_en = 1'b1; load_in = ld; store_in = st;
    alu_res = a; op_b = d; instruction_in = ins;
    idle_exp(); e_stall = 1'b1;
    tick();
    if (is_bad(ld, st, f3, a)) begin
      noise(); idle_exp(); e_err = 1'b1;
      tick();
    end else begin
      nreq = (wait_n >= TMO) ? TMO : wait_n + 1;
      for (int i = 0; i < nreq; i++) begin
        noise();
        dbus_ready = (i == wait_n);
        if (i == wait_n) dbus_rdata = rd;
        idle_exp();
        e_stall = 1'b1; e_req = 1'b1; e_we = st;
        e_addr = {a[31:2], 2'b00};
        e_wmask = mask_of(st, f3, a[1:0]);
        e_wdata = wdata_of(f3, d);
        tick();
      end
      noise(); idle_exp();
      if (wait_n >= TMO) e_err = 1'b1;
      else begin
        e_lv = ld;
        if (ld) e_ld = fmt(f3, a[1:0], rd);
      end
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (n_cmp=%0d)", n_cmp);
    $fatal(1);
  end

  initial begin
    logic r_ld, r_st;
    int   r, w;
    // Model self-pins against hand-computed values.
    chk("pin_lb",    fmt(3'd0, 2'd3, 32'h80FF_1234), 32'hFFFF_FF80);
    chk("pin_lhu",   fmt(3'd5, 2'd2, 32'h80FF_1234), 32'h0000_80FF);
    chk("pin_sh_m",  {28'd0, mask_of(1'b1, 3'd1, 2'd2)}, 32'h0000_000C);
    chk("pin_sh_d",  wdata_of(3'd1, 32'hDEAD_BEEF), 32'hBEEF_BEEF);
    chk("pin_lw_ua", {31'd0, is_bad(1'b1, 1'b0, 3'd2, 32'h6)}, 32'd1);

    // Reset with a pending start request on the inputs: no stall.
    noise();
    rst = 1'b1; mem_en = 1'b1; load_in = 1'b1; store_in = 1'b0;
    tick();
    idle_exp(); e_ld = 32'd0; chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    idle_cycle();

    do_op(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 0);   // LB, fast ready
    idle_cycle();
    do_op(1'b0, 1'b1, 3'd1, 32'h202, 32'hDEAD_BEEF, 32'h0, 2);   // SH upper half
    do_op(1'b1, 1'b0, 3'd2, 32'h006, 32'h0, 32'h0, 0);           // misaligned LW
    do_op(1'b1, 1'b0, 3'd5, 32'h10, 32'h0, 32'h0, 1000);         // LHU timeout
    do_op(1'b1, 1'b1, 3'd2, 32'h20, 32'h0, 32'h0, 0);            // load+store both
    do_op(1'b1, 1'b0, 3'd2, 32'h40, 32'h0, 32'hCAFE_F00D, 3);    // LW

    // Reset on the third REQ cycle of an LW; later ready must be ignored.
    noise();
    mem_en = 1'b1; load_in = 1'b1; store_in = 1'b0; alu_res = 32'h80;
    instruction_in = 32'h0000_2000;
    idle_exp(); e_stall = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      noise();
      dbus_ready = 1'b0;
      idle_exp(); e_req = 1'b1; e_addr = 32'h80; e_wmask = 4'b0000;
      if (i == 2) begin rst = 1'b1; e_stall = 1'b0; end
      else e_stall = 1'b1;
      tick();
    end
    rst = 1'b0;
    e_ld = 32'd0;
    for (int i = 0; i < 3; i++) begin
      mem_en = 1'b0; load_in = 1'b0; store_in = 1'b0;
      dbus_ready = 1'b1; dbus_rdata = $urandom;
      idle_exp();
      tick();
    end

    // Random traffic.
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      r_ld = (r < 4) || (r >= 8);
      r_st = (r >= 4 && r < 9);
      w = $urandom_range(0, 3);
      if ($urandom_range(0, 60) == 0) w = 300;
      do_op(r_ld, r_st, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, w);
      for (int k = $urandom_range(0, 2); k > 0; k--) idle_cycle();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
